// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step shift/rotate sequencer for the 16-bit ALU shift path
//
// Applies one single-bit shift/rotate step per clock, `amount` times, then
// presents the registered result and C/Z/N/P flags for one done cycle.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   load a new operation (honoured in IDLE or DONE only)
//   abort     in   cancel an operation while in SHIFT
//   F         in   opcode: SHL SHR SAL SAR ROL ROR RCL RCR (000..111)
//   A         in   operand
//   amount    in   number of single-bit steps
//   carry_in  in   initial carry register value
//   busy      out  high while steps are being applied
//   done      out  one-cycle pulse, Out and flags valid
//   Out       out  result register
//   C/Z/N/P   out  carry, zero, negative, even-parity flags
module shift_sequencer #(
   parameter int Width = 16,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       F,
   input  logic [Width-1:0] A,
   input  logic [AW-1:0]    amount,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [Width-1:0] Out,
   output logic             C,
   output logic             Z,
   output logic             N,
   output logic             P
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [Width-1:0] acc_q, acc_d;
   logic             c_q, c_d;
   logic [AW-1:0]    count_q, count_d;
   logic [Width-1:0] out_q;
   logic             cf_q, z_q, n_q, p_q;

   // One step; returns {new carry, new acc}. The carry used by RCL/RCR is
   // the registered value from before this step.
   function automatic logic [Width:0] step_f(input logic [2:0] op,
                                             input logic [Width-1:0] acc,
                                             input logic c);
      logic [Width:0] r;
      case (op)
         3'b000, 3'b010: r = {acc[Width-1], acc[Width-2:0], 1'b0};
         3'b001:         r = {acc[0], 1'b0, acc[Width-1:1]};
         3'b011:         r = {acc[0], acc[Width-1], acc[Width-1:1]};
         3'b100:         r = {acc[Width-1], acc[Width-2:0], acc[Width-1]};
         3'b101:         r = {acc[0], acc[0], acc[Width-1:1]};
         3'b110:         r = {acc[Width-1], acc[Width-2:0], c};
         default:        r = {acc[0], c, acc[Width-1:1]};
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      c_d     = c_q;
      count_d = count_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               op_d    = F;
               acc_d   = A;
               c_d     = carry_in;
               count_d = amount;
               state_d = (amount == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               {c_d, acc_d} = step_f(op_q, acc_q, c_q);
               count_d      = count_q - AW'(1);
               if (count_q == AW'(1)) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         count_q <= '0;
         out_q   <= '0;
         cf_q    <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         p_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         count_q <= count_d;
         // Result registers load only on entry to DONE (including a
         // DONE->DONE reload), so intermediate acc values never show.
         if (state_d == S_DONE) begin
            out_q <= acc_d;
            cf_q  <= c_d;
            z_q   <= (acc_d == '0);
            n_q   <= acc_d[Width-1];
            p_q   <= ~^acc_d;
         end
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign Out  = out_q;
   assign C    = cf_q;
   assign Z    = z_q;
   assign N    = n_q;
   assign P    = p_q;

endmodule
